// File: rtl/rv_fetch_buf.sv
// Instruction fetch buffer: one word read per PC, {pc, instr} FIFO toward decode.
// Optional bus-error support is enabled by defining FETCH_BUS_ERR_EN.
module rv_fetch_buf #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [29:0] i_pc,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        o_bus_req,
  output logic [29:0] o_bus_addr,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
`ifdef FETCH_BUS_ERR_EN
  input  logic        i_bus_err,
  output logic        o_fault,
`endif
  output logic        o_valid,
  output logic [29:0] o_pc,
  output logic [31:0] o_instr,
  input  logic        i_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LAST_SLOT = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] PTR_INC   = (AW+1)'(1);

`ifdef FETCH_BUS_ERR_EN
  typedef enum logic [1:0] {IDLE, REQ, DROP, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
`endif

  state_t state, state_nxt;

  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        empty, full, pop, push, space, addr_load;
  logic [29:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
`ifdef FETCH_BUS_ERR_EN
  logic        fault_mem [DEPTH];
  logic        push_fault;
`endif

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  // A pop during a flush is not a transfer: the flush wins.
  assign pop   = !empty && i_ready && !i_flush;
  assign space = !full || pop;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    addr_load = 1'b0;
    o_bus_req = 1'b0;
    o_stall   = 1'b1;
`ifdef FETCH_BUS_ERR_EN
    push_fault = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!i_flush && space) begin
          state_nxt = REQ;
          addr_load = 1'b1;
        end
      end
      REQ: begin
        o_bus_req = 1'b1;
        o_stall   = !(i_bus_ack && !i_flush);
        if (i_bus_ack) begin
          if (i_flush) begin
            state_nxt = IDLE;
          end else begin
            push = 1'b1;
`ifdef FETCH_BUS_ERR_EN
            if (i_bus_err) begin
              push_fault = 1'b1;
              state_nxt  = HALT;
            end else
`endif
            // Keep streaming only if the FIFO still has room after this cycle.
            if (pop || (count < LAST_SLOT)) begin
              addr_load = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end else if (i_flush) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        o_bus_req = 1'b1;
        if (i_bus_ack) state_nxt = IDLE;
      end
`ifdef FETCH_BUS_ERR_EN
      HALT: begin
        if (i_flush) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      o_bus_addr <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state <= state_nxt;
      if (addr_load) o_bus_addr <= i_pc;
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_INC;
        if (pop)  rd_ptr <= rd_ptr + PTR_INC;
      end
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr[AW-1:0]] <= o_bus_addr;
`ifdef FETCH_BUS_ERR_EN
      instr_mem[wr_ptr[AW-1:0]] <= push_fault ? NOP_INSTR : i_bus_rdata;
      fault_mem[wr_ptr[AW-1:0]] <= push_fault;
`else
      instr_mem[wr_ptr[AW-1:0]] <= i_bus_rdata;
`endif
    end
  end

  assign o_valid = !empty;
  assign o_pc    = empty ? '0 : pc_mem[rd_ptr[AW-1:0]];
  assign o_instr = empty ? NOP_INSTR : instr_mem[rd_ptr[AW-1:0]];
`ifdef FETCH_BUS_ERR_EN
  assign o_fault = !empty && fault_mem[rd_ptr[AW-1:0]];
`endif

endmodule

// File: tb/tb_rv_fetch_buf.sv
// Directed bench for rv_fetch_buf with a PC-generator model and a simple bus model.
// Define FETCH_BUS_ERR_EN to build and exercise the bus-error variant.
module tb_rv_fetch_buf;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [29:0] pc;
  logic        flush;
  logic        stall;
  logic        bus_req;
  logic [29:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        valid;
  logic [29:0] head_pc;
  logic [31:0] instr;
  logic        ready;
`ifdef FETCH_BUS_ERR_EN
  logic        bus_err;
  logic        fault;
`endif

  // Bench-side stimulus controls
  logic        auto_ack, man_ack, man_data_en;
  logic [31:0] man_rdata;
  logic [29:0] flush_pc, pc_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // PC generator: presents the next PC when not stalled, the target on redirect.
  assign pc = flush ? flush_pc : (stall ? pc_reg : pc_reg + 30'd1);
  always @(posedge clk) pc_reg <= !reset_n ? 30'd0 : pc;

  // Bus: optionally acks every request, data defaults to the byte address.
  assign bus_ack   = auto_ack ? bus_req : man_ack;
  assign bus_rdata = man_data_en ? man_rdata : {bus_addr, 2'b00};

  rv_fetch_buf #(.DEPTH(2), .NOP_INSTR(32'h0000_0013)) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_pc        (pc),
    .i_flush     (flush),
    .o_stall     (stall),
    .o_bus_req   (bus_req),
    .o_bus_addr  (bus_addr),
    .i_bus_ack   (bus_ack),
    .i_bus_rdata (bus_rdata),
`ifdef FETCH_BUS_ERR_EN
    .i_bus_err   (bus_err),
    .o_fault     (fault),
`endif
    .o_valid     (valid),
    .o_pc        (head_pc),
    .o_instr     (instr),
    .i_ready     (ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
    end
  endtask

  // Returns at a falling edge with reset released and the DUT in IDLE.
  task automatic do_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    auto_ack    = 1'b0;
    man_ack     = 1'b0;
    man_data_en = 1'b0;
    man_rdata   = '0;
    flush       = 1'b0;
    flush_pc    = '0;
    ready       = 1'b0;
`ifdef FETCH_BUS_ERR_EN
    bus_err     = 1'b0;
`endif
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int exp_pc, exp_fetch, pops, cyc, lat, waitc;

    reset_n = 1'b0; auto_ack = 1'b0; man_ack = 1'b0; man_data_en = 1'b0;
    man_rdata = '0; flush = 1'b0; flush_pc = '0; ready = 1'b0;
`ifdef FETCH_BUS_ERR_EN
    bus_err = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_instr", instr, 32'h13);
    check("rst_pc", head_pc, 0);
    check("rst_req", bus_req, 0);
    check("rst_stall", stall, 1);

    // Streaming: ack every cycle, decode always ready.
    do_reset();
    auto_ack = 1'b1;
    ready    = 1'b1;
    @(negedge clk); #1;
    check("t1_req", bus_req, 1);
    check("t1_addr0", bus_addr, 0);
    check("t1_stall_ack", stall, 0);
    check("t1_fill_valid", valid, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      check("t1_valid", valid, 1);
      check("t1_pc", head_pc, k);
      check("t1_instr", instr, 32'(k * 4));
      check("t1_stall", stall, 0);
    end

    // Mid-operation reset aborts everything.
    do_reset(); #1;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_instr", instr, 32'h13);
    check("mid_rst_req", bus_req, 0);

    // Back-pressure: decode stalled, FIFO fills to DEPTH then fetching stops.
    auto_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    check("t2_full_valid", valid, 1);
    check("t2_full_pc", head_pc, 0);
    check("t2_full_req", bus_req, 0);
    check("t2_full_stall", stall, 1);
    @(negedge clk);
    ready = 1'b1;
    #1;
    check("t2_hold_req", bus_req, 0);
    @(negedge clk);
    ready = 1'b0;
    #1;
    check("t2_pop_pc", head_pc, 1);
    check("t2_refetch_req", bus_req, 1);
    check("t2_refetch_addr", bus_addr, 2);
    @(negedge clk); #1;
    check("t2_refull_req", bus_req, 0);
    check("t2_refull_pc", head_pc, 1);
    // Flush with a pop on a full FIFO.
    ready    = 1'b1;
    flush    = 1'b1;
    flush_pc = 30'h40;
    #1;
    check("t2_flush_stall", stall, 1);
    @(negedge clk);
    flush = 1'b0;
    ready = 1'b0;
    #1;
    check("t2_flush_valid", valid, 0);
    check("t2_flush_instr", instr, 32'h13);
    @(negedge clk); #1;
    check("t2_redirect_addr", bus_addr, 30'h40);

    // Flush with a request outstanding: late data must be dropped.
    do_reset();
    ready       = 1'b1;
    man_data_en = 1'b1;
    @(negedge clk); #1;
    check("t3_req", bus_req, 1);
    check("t3_addr", bus_addr, 0);
    check("t3_wait_stall", stall, 1);
    flush    = 1'b1;
    flush_pc = 30'h100;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("t3_drop_req", bus_req, 1);
    check("t3_drop_valid", valid, 0);
    @(negedge clk); #1;
    check("t3_drop_req2", bus_req, 1);
    @(negedge clk);
    man_ack   = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    #1;
    check("t3_drop_ack_stall", stall, 1);
    @(negedge clk);
    man_ack = 1'b0;
    #1;
    check("t3_dropped_valid", valid, 0);
    check("t3_dropped_instr", instr, 32'h13);
    check("t3_idle_req", bus_req, 0);
    @(negedge clk); #1;
    check("t3_new_req", bus_req, 1);
    check("t3_new_addr", bus_addr, 30'h100);
    man_ack   = 1'b1;
    man_rdata = 32'h55;
    #1;
    check("t3_new_stall", stall, 0);
    @(negedge clk);
    man_ack = 1'b0;
    #1;
    check("t3_head_valid", valid, 1);
    check("t3_head_pc", head_pc, 30'h100);
    check("t3_head_instr", instr, 32'h55);
    check("t3_next_addr", bus_addr, 30'h101);

    // Flush colliding with an ack and a pop in the same cycle.
    man_ack   = 1'b1;
    man_rdata = 32'h77;
    flush     = 1'b1;
    flush_pc  = 30'h200;
    #1;
    check("t4_stall", stall, 1);
    @(negedge clk);
    man_ack = 1'b0;
    flush   = 1'b0;
    #1;
    check("t4_valid", valid, 0);
    check("t4_instr", instr, 32'h13);
    check("t4_idle_req", bus_req, 0);
    @(negedge clk); #1;
    check("t4_req", bus_req, 1);
    check("t4_addr", bus_addr, 30'h200);
    check("t4_still_empty", valid, 0);

    // Random ack latency and decode readiness against an in-order reference.
    do_reset();
    exp_pc = 0; exp_fetch = 0; pops = 0; cyc = 0; waitc = 0;
    lat = $urandom_range(0, 4);
    while (pops < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      ready   = ($urandom_range(0, 3) != 0);
      man_ack = bus_req && (waitc >= lat);
      #1;
      if (man_ack) begin
        check("t5_addr", bus_addr, 32'(exp_fetch));
        exp_fetch++;
        waitc = 0;
        lat   = $urandom_range(0, 4);
      end else if (bus_req) begin
        waitc++;
      end
      if (valid) begin
        if (ready) begin
          check("t5_pc", head_pc, 32'(exp_pc));
          check("t5_instr", instr, 32'(exp_pc * 4));
          exp_pc++;
          pops++;
        end
      end else begin
        check("t5_nop", instr, 32'h13);
      end
    end
    check("t5_done", pops, 1000);

`ifdef FETCH_BUS_ERR_EN
    // Bus error: faulted NOP entry, then no requests until a redirect.
    do_reset();
    flush    = 1'b1;
    flush_pc = 30'h10;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk); #1;
    check("t6_addr", bus_addr, 30'h10);
    check("t6_no_fault", fault, 0);
    man_ack = 1'b1;
    bus_err = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    bus_err = 1'b0;
    #1;
    check("t6_valid", valid, 1);
    check("t6_fault", fault, 1);
    check("t6_instr", instr, 32'h13);
    check("t6_pc", head_pc, 30'h10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("t6_halt_req", bus_req, 0);
      check("t6_halt_stall", stall, 1);
    end
    flush    = 1'b1;
    flush_pc = 30'h20;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("t6_flush_fault", fault, 0);
    check("t6_flush_valid", valid, 0);
    @(negedge clk); #1;
    check("t6_resume_req", bus_req, 1);
    check("t6_resume_addr", bus_addr, 30'h20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
